// File: rtl/debug_loader.sv
// debug_loader: byte-stream program loader for the core's debug load port.
//   Frame: MAGIC | count lo | count hi | count x 4 LE data bytes | XOR checksum.
//   Each assembled word becomes one instruction-memory write at BASE_ADDR + 4*i.
//   DEBUG_SIG stays high for the whole frame so the frontend remains in load mode.
// Ports:
//   clk, nrst            core clock, asynchronous active-low reset
//   rx_valid/rx_data     incoming byte stream; rx_ready accepts a byte
//   DEBUG_SIG            load mode active
//   DEBUG_addr/instr     write address/data, valid while debug_we is high
//   debug_we             one-cycle write strobe per word
//   load_done/load_err   one-cycle frame result pulses
module debug_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        DEBUG_SIG,
  output logic [31:0] DEBUG_addr,
  output logic [31:0] DEBUG_instr,
  output logic        debug_we,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_WRITE, S_CHECK, S_FIN
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  chk_q, chk_d;
  logic        chk_ok_q, chk_ok_d;
  logic        cnt_err_q, cnt_err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        live_q;   // keeps rx_ready low until the first edge after reset

  logic        acc;
  logic [15:0] cnt_full;
  logic        cnt_too_big;

  assign acc         = rx_valid & rx_ready;
  assign cnt_full    = {rx_data, cnt_q[7:0]};
  assign cnt_too_big = 32'(cnt_full) > MAX_WORDS;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (acc && rx_data == MAGIC) state_d = S_CNT_LO;
      S_CNT_LO: if (acc) state_d = S_CNT_HI;
      S_CNT_HI: if (acc) begin
        if (cnt_too_big)          state_d = S_IDLE;
        else if (cnt_full == '0)  state_d = S_CHECK;
        else                      state_d = S_DATA;
      end
      S_DATA:   if (acc && bidx_q == 2'd3) state_d = S_WRITE;
      S_WRITE:  state_d = (widx_q + 16'd1 == cnt_q) ? S_CHECK : S_DATA;
      S_CHECK:  if (acc) state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rx_ready  = 1'b0;
    DEBUG_SIG = 1'b0;
    debug_we  = 1'b0;
    load_done = 1'b0;
    load_err  = cnt_err_q;  // bad count reports in the IDLE cycle that follows
    case (state_q)
      S_IDLE:   rx_ready = live_q;
      S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK: begin
        rx_ready  = 1'b1;
        DEBUG_SIG = 1'b1;
      end
      S_WRITE: begin
        DEBUG_SIG = 1'b1;
        debug_we  = 1'b1;
      end
      S_FIN: begin
        load_done = chk_ok_q;
        load_err  = ~chk_ok_q;
      end
      default: ;
    endcase
  end

  assign DEBUG_addr  = addr_q;
  assign DEBUG_instr = instr_q;

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    word_d    = word_q;
    chk_d     = chk_q;
    chk_ok_d  = chk_ok_q;
    cnt_err_d = 1'b0;
    addr_d    = addr_q;
    instr_d   = instr_q;
    case (state_q)
      S_IDLE: if (acc && rx_data == MAGIC) begin
        widx_d = '0;
        bidx_d = '0;
        chk_d  = '0;
      end
      S_CNT_LO: if (acc) cnt_d[7:0] = rx_data;
      S_CNT_HI: if (acc) begin
        cnt_d[15:8] = rx_data;
        cnt_err_d   = cnt_too_big;
      end
      S_DATA: if (acc) begin
        word_d[{bidx_q, 3'b000} +: 8] = rx_data;
        chk_d  = chk_q ^ rx_data;
        bidx_d = bidx_q + 2'd1;
        // Load the output registers on the last byte so they are valid in WRITE.
        if (bidx_q == 2'd3) begin
          addr_d  = BASE_ADDR + {14'd0, widx_q, 2'b00};
          instr_d = {rx_data, word_q[23:0]};
        end
      end
      S_WRITE: widx_d = widx_q + 16'd1;
      S_CHECK: if (acc) chk_ok_d = (rx_data == chk_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      word_q    <= '0;
      chk_q     <= '0;
      chk_ok_q  <= 1'b0;
      cnt_err_q <= 1'b0;
      addr_q    <= '0;
      instr_q   <= '0;
      live_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      bidx_q    <= bidx_d;
      word_q    <= word_d;
      chk_q     <= chk_d;
      chk_ok_q  <= chk_ok_d;
      cnt_err_q <= cnt_err_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      live_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_loader.sv
// tb_debug_loader: frame-level reference model for debug_loader.
//   The driver knows each frame it sends, so it derives the expected writes,
//   checksum and result from the frame contents and records in which cycle each
//   pulse must appear. A negedge compare process checks every output each cycle.
module tb_debug_loader;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          MAXW  = 1024;
  localparam logic [7:0]  MAGIC = 8'hA5;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, DEBUG_SIG, debug_we, load_done, load_err;
  logic [31:0] DEBUG_addr, DEBUG_instr;

  int cyc = 0;
  int npass = 0;
  int ntot = 0;
  // cycle numbers in which a one-cycle pulse is expected (-1: none pending)
  int exp_we_cyc = -1;
  int exp_done_cyc = -1;
  int exp_err_cyc = -1;
  int exp_fin_cyc = -1;
  logic        exp_sig = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp_instr = 32'h0;
  logic [31:0] wsrc[$];

  debug_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .MAGIC(MAGIC)) dut (
    .clk(clk), .nrst(nrst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .DEBUG_SIG(DEBUG_SIG), .DEBUG_addr(DEBUG_addr),
    .DEBUG_instr(DEBUG_instr), .debug_we(debug_we), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string nm, input logic act, input logic want);
    ntot++;
    if (act === want) npass++;
    else $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, want, cyc);
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] want);
    ntot++;
    if (act === want) npass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
  endtask

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  function automatic int pick(input int s);
    return (s < 0) ? int'($urandom_range(0, 2)) : s;
  endfunction

  always @(negedge clk) begin
    chk1("debug_we",    debug_we,    cyc == exp_we_cyc);
    chk1("load_done",   load_done,   cyc == exp_done_cyc);
    chk1("load_err",    load_err,    cyc == exp_err_cyc);
    chk1("DEBUG_SIG",   DEBUG_SIG,   exp_sig);
    chk32("DEBUG_addr",  DEBUG_addr,  exp_addr);
    chk32("DEBUG_instr", DEBUG_instr, exp_instr);
    if (cyc == exp_we_cyc || cyc == exp_fin_cyc) chk1("rx_ready_busy", rx_ready, 1'b0);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Starts and ends at posedge+1; returns in the cycle after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int stall);
    int n;
    idle(stall);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 64) begin
        ntot++;
        $display("FAIL rx_timeout: byte %h not accepted within 64 cycles", b);
        rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Sends one complete frame; words come from wsrc if queued, else random.
  // ckx is XORed into the true checksum (nonzero -> corrupt frame).
  task automatic run_frame(input int cnt, input int stall, input logic [7:0] ckx);
    logic [15:0] c16;
    logic [7:0]  ck;
    logic [31:0] w;
    c16 = 16'(cnt);
    send_byte(MAGIC, pick(stall));
    exp_sig = 1'b1;
    send_byte(c16[7:0], pick(stall));
    send_byte(c16[15:8], pick(stall));
    if (cnt > MAXW) begin
      exp_sig = 1'b0;
      exp_err_cyc = cyc;
      return;
    end
    ck = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      w = (wsrc.size() > 0) ? wsrc.pop_front() : $urandom;
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8], pick(stall));
        ck ^= w[8*j +: 8];
      end
      exp_we_cyc = cyc;
      exp_addr   = BASE + 32'(i * 4);
      exp_instr  = w;
    end
    send_byte(ck ^ ckx, pick(stall));
    exp_sig = 1'b0;
    exp_fin_cyc = cyc;
    if (ckx != 8'h00) exp_err_cyc = cyc;
    else              exp_done_cyc = cyc;
  endtask

  initial begin
    logic [31:0] w0, w1, w2;
    int cnt;
    logic [7:0] ckx;

    // pin the checksum model with hand-computed values
    chk32("model_chk_words_13_100093", {24'h0, xor4(32'h0000_0013) ^ xor4(32'h0010_0093)}, 32'h90);
    chk32("model_chk_word_12345678",   {24'h0, xor4(32'h1234_5678)}, 32'h08);

    #1;
    chk1("rst_rx_ready", rx_ready, 1'b0);
    chk1("rst_DEBUG_SIG", DEBUG_SIG, 1'b0);
    chk1("rst_debug_we", debug_we, 1'b0);
    chk1("rst_load_done", load_done, 1'b0);
    chk1("rst_load_err", load_err, 1'b0);
    chk32("rst_DEBUG_addr", DEBUG_addr, 32'h0);
    chk32("rst_DEBUG_instr", DEBUG_instr, 32'h0);
    repeat (2) @(posedge clk);
    #2 nrst = 1'b1;
    #1 chk1("rx_ready_before_first_edge", rx_ready, 1'b0);
    @(posedge clk); #1;
    chk1("rx_ready_after_first_edge", rx_ready, 1'b1);

    // two-word frame, good checksum
    wsrc = '{32'h0000_0013, 32'h0010_0093};
    run_frame(2, 0, 8'h00);
    idle(3);
    // one word, checksum byte 0x00 instead of 0x08
    wsrc = '{32'h1234_5678};
    run_frame(1, 0, 8'h08);
    idle(2);
    // count 0x0401 exceeds the limit
    run_frame(32'h0401, 0, 8'h00);
    idle(2);
    // leading garbage, then an empty frame
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    run_frame(0, 0, 8'h00);
    idle(2);
    // same three words unstalled and with 1-of-3-cycle valid
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    wsrc = '{w0, w1, w2};
    run_frame(3, 0, 8'h00);
    wsrc = '{w0, w1, w2};
    run_frame(3, 2, 8'h00);
    // MAGIC bytes inside data are plain data
    wsrc = '{32'hA5A5_A5A5, 32'h0000_00A5};
    run_frame(2, -1, 8'h00);
    // count boundaries
    run_frame(MAXW, 0, 8'h00);
    run_frame(MAXW + 1, 0, 8'h00);
    // random frames
    for (int k = 0; k < 12; k++) begin
      cnt = int'($urandom_range(0, 6));
      ckx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 8'hA4)), pick(-1));
      run_frame(cnt, -1, ckx);
      idle(int'($urandom_range(0, 3)));
    end

    // reset after the second data byte of a frame
    send_byte(MAGIC, 0);
    exp_sig = 1'b1;
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    exp_sig = 1'b0; exp_addr = 32'h0; exp_instr = 32'h0;
    exp_we_cyc = -1; exp_done_cyc = -1; exp_err_cyc = -1; exp_fin_cyc = -1;
    nrst = 1'b0;
    #1;
    chk1("midrst_DEBUG_SIG", DEBUG_SIG, 1'b0);
    chk1("midrst_rx_ready", rx_ready, 1'b0);
    chk1("midrst_debug_we", debug_we, 1'b0);
    chk32("midrst_DEBUG_addr", DEBUG_addr, 32'h0);
    chk32("midrst_DEBUG_instr", DEBUG_instr, 32'h0);
    @(posedge clk);
    #2 nrst = 1'b1;
    #1 chk1("midrst_rx_ready_release", rx_ready, 1'b0);
    @(posedge clk); #1;
    wsrc = '{32'hCAFE_F00D};
    run_frame(1, 0, 8'h00);
    chk32("fresh_frame_addr", DEBUG_addr, BASE);
    chk32("fresh_frame_instr", DEBUG_instr, 32'hCAFE_F00D);
    idle(3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
